t03_mem_request_ctrl: RTL and testbench

Parametrised memory request controller between the single-cycle core and the wishbone manager / MMIO. It sequences instruction fetch and data load/store requests over one shared bus port and generates byte, half and word byte-lane enables. It aligns and extends load data, and latches the fetched instruction. Misaligned data accesses and, optionally, bus timeouts drive it into a sticky fault state.

---
 rtl/t03_mem_request_ctrl_pkg.sv | 35 +++
 rtl/t03_mem_request_ctrl_load_align.sv | 26 ++
 rtl/t03_mem_request_ctrl.sv | 160 ++++++++++++++++
 tb/tb_t03_mem_request_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t03_mem_request_ctrl_pkg.sv
// Shared types and constants for the t03 memory request controller.
// The optional bus-timeout fault is compiled in with T03_REQ_TIMEOUT_EN.
package t03_req_pkg;

   typedef enum logic [2:0] {
      ST_START,
      ST_FETCH,
      ST_DECODE,
      ST_DATA_RD,
      ST_DATA_WR,
      ST_FAULT
   } req_state_t;

   typedef enum logic [1:0] {
      SZ_BYTE     = 2'b00,
      SZ_HALF     = 2'b01,
      SZ_WORD     = 2'b10,
      SZ_WORD_ALT = 2'b11
   } mem_size_t;

   localparam logic [1:0]  CAUSE_NONE     = 2'b00;
   localparam logic [1:0]  CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0]  CAUSE_TIMEOUT  = 2'b10;
   localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

   // Size 11 behaves as a word access, so it shares the word alignment rule.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return off[0];
         default: return off != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/t03_mem_request_ctrl_load_align.sv
// Load lane selection and sign/zero extension for byte, half and word loads.
module t03_load_align
   import t03_req_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_off,
   input  logic [1:0]  i_mem_size,
   input  logic        i_mem_unsigned,
   output logic [31:0] o_result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
   assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

   always_comb begin
      case (i_mem_size)
         SZ_BYTE: o_result = {{24{~i_mem_unsigned & w_byte[7]}}, w_byte};
         SZ_HALF: o_result = {{16{~i_mem_unsigned & w_half[15]}}, w_half};
         default: o_result = i_rdata;
      endcase
   end

endmodule

// File: rtl/t03_mem_request_ctrl.sv
// Fetch / load / store sequencer sharing one bus port, with sticky fault state.
// Define T03_REQ_TIMEOUT_EN to compile in the bus-timeout counter and cause 10.
module t03_mem_request_ctrl
   import t03_req_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_ack,
   input  logic [31:0]       i_rdata,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic [1:0]        i_mem_size,
   input  logic              i_mem_unsigned,
   input  logic [ADDR_W-1:0] i_pc,
   input  logic [ADDR_W-1:0] i_alu_addr,
   input  logic [31:0]       i_store_data,
   output logic              o_read,
   output logic              o_write,
   output logic [ADDR_W-1:0] o_address,
   output logic [3:0]        o_sel,
   output logic [31:0]       o_wdata,
   output logic [31:0]       o_instr,
   output logic [31:0]       o_load_data,
   output logic              o_freeze_pc,
   output logic              o_freeze_instr,
   output logic              o_fault,
   output logic [1:0]        o_fault_cause
);

   req_state_t  r_state, w_state_next;
   logic [31:0] r_instr, r_load_data;
   logic        r_fault;
   logic [1:0]  r_cause, w_cause_next;
   logic [1:0]  w_off;
   logic [3:0]  w_sel;
   logic [31:0] w_wdata, w_load_aligned;
   logic        w_timeout;
   logic        w_unused;

   assign w_off    = i_alu_addr[1:0];
   assign w_unused = ^i_pc[1:0];

`ifdef T03_REQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_cnt;
   logic             w_waiting;

   assign w_waiting = ((r_state == ST_FETCH) || (r_state == ST_DATA_RD) ||
                       (r_state == ST_DATA_WR)) && !i_ack;
   // The cycle whose increment would reach the limit is the one that faults.
   assign w_timeout = w_waiting && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          r_cnt <= '0;
      else if (w_state_next != r_state) r_cnt <= '0;
      else if (w_waiting)               r_cnt <= r_cnt + 1'b1;
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign w_timeout = 1'b0;
`endif

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_sel[gi] = (i_mem_size == SZ_BYTE) ? (w_off == 2'(gi)) :
                         (i_mem_size == SZ_HALF) ? (w_off[1] == 1'(gi / 2)) : 1'b1;
      assign w_wdata[8*gi +: 8] = (i_mem_size == SZ_BYTE) ? i_store_data[7:0] :
                                  (i_mem_size == SZ_HALF) ? i_store_data[8*(gi%2) +: 8] :
                                                            i_store_data[8*gi +: 8];
   end

   t03_load_align u_load_align (
      .i_rdata        (i_rdata),
      .i_off          (w_off),
      .i_mem_size     (i_mem_size),
      .i_mem_unsigned (i_mem_unsigned),
      .o_result       (w_load_aligned)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_START;
         r_instr     <= NOP_INSTR;
         r_load_data <= '0;
         r_fault     <= 1'b0;
         r_cause     <= CAUSE_NONE;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_FETCH && i_ack)   r_instr     <= i_rdata;
         if (r_state == ST_DATA_RD && i_ack) r_load_data <= w_load_aligned;
         if (w_state_next == ST_FAULT && r_state != ST_FAULT) begin
            r_fault <= 1'b1;
            r_cause <= w_cause_next;
         end
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_cause_next   = CAUSE_NONE;
      o_read         = 1'b0;
      o_write        = 1'b0;
      o_address      = '0;
      o_sel          = '0;
      o_wdata        = '0;
      o_freeze_pc    = 1'b1;
      o_freeze_instr = 1'b1;
      case (r_state)
         ST_START: w_state_next = ST_FETCH;
         ST_FETCH: begin
            o_read    = 1'b1;
            o_address = {i_pc[ADDR_W-1:2], 2'b00};
            o_sel     = 4'b1111;
            if (i_ack) begin
               o_freeze_instr = 1'b0;
               w_state_next   = ST_DECODE;
            end else if (w_timeout) begin
               w_state_next = ST_FAULT;
               w_cause_next = CAUSE_TIMEOUT;
            end
         end
         ST_DECODE: begin
            if (i_mem_read || i_mem_write) begin
               if (is_misaligned(i_mem_size, w_off)) begin
                  w_state_next = ST_FAULT;
                  w_cause_next = CAUSE_MISALIGN;
               end else begin
                  w_state_next = i_mem_read ? ST_DATA_RD : ST_DATA_WR;
               end
            end else begin
               o_freeze_pc  = 1'b0;
               w_state_next = ST_FETCH;
            end
         end
         ST_DATA_RD, ST_DATA_WR: begin
            o_read    = (r_state == ST_DATA_RD);
            o_write   = (r_state == ST_DATA_WR);
            o_address = {i_alu_addr[ADDR_W-1:2], 2'b00};
            o_sel     = w_sel;
            o_wdata   = w_wdata;
            if (i_ack) begin
               o_freeze_pc  = 1'b0;
               w_state_next = ST_FETCH;
            end else if (w_timeout) begin
               w_state_next = ST_FAULT;
               w_cause_next = CAUSE_TIMEOUT;
            end
         end
         default: ;
      endcase
   end

   assign o_instr       = r_instr;
   assign o_load_data   = r_load_data;
   assign o_fault       = r_fault;
   assign o_fault_cause = r_cause;

endmodule

// File: tb/tb_t03_mem_request_ctrl.sv
// Self-checking bench for t03_mem_request_ctrl: directed cases plus random traffic
// against a transaction-level model. Timeout cases run when T03_REQ_TIMEOUT_EN is defined.
module tb_t03_mem_request_ctrl;

   localparam int TO_CYC = 8;
`ifdef T03_REQ_TIMEOUT_EN
   localparam bit TO_ON = 1'b1;
`else
   localparam bit TO_ON = 1'b0;
`endif
   localparam int P_START = 0, P_FETCH = 1, P_DECODE = 2, P_RD = 3, P_WR = 4, P_FAULT = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        ack;
   logic [31:0] rdata;
   logic        mem_read, mem_write, mem_unsigned;
   logic [1:0]  mem_size;
   logic [31:0] pc, alu_addr, store_data;
   logic        o_read, o_write, o_freeze_pc, o_freeze_instr, o_fault;
   logic [31:0] o_address, o_wdata, o_instr, o_load_data;
   logic [3:0]  o_sel;
   logic [1:0]  o_fault_cause;

   int n_cmp = 0;
   int n_bad = 0;

   t03_mem_request_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk(clk), .rst(rst), .i_ack(ack), .i_rdata(rdata),
      .i_mem_read(mem_read), .i_mem_write(mem_write), .i_mem_size(mem_size),
      .i_mem_unsigned(mem_unsigned), .i_pc(pc), .i_alu_addr(alu_addr),
      .i_store_data(store_data), .o_read(o_read), .o_write(o_write),
      .o_address(o_address), .o_sel(o_sel), .o_wdata(o_wdata), .o_instr(o_instr),
      .o_load_data(o_load_data), .o_freeze_pc(o_freeze_pc),
      .o_freeze_instr(o_freeze_instr), .o_fault(o_fault), .o_fault_cause(o_fault_cause)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit misal(input logic [1:0] sz, input logic [31:0] a);
      return (a % nbytes(sz)) != 0;
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] d, input logic [31:0] a,
                                            input logic [1:0] sz, input logic uns);
      int nb = nbytes(sz);
      int off = int'(a % 4) / nb * nb;
      logic [31:0] mask, v;
      if (nb == 4) return d;
      mask = (32'h1 << (8 * nb)) - 32'h1;
      v = (d >> (8 * off)) & mask;
      if (!uns && v[8*nb-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [31:0] exp_sel(input logic [1:0] sz, input logic [31:0] a);
      int nb = nbytes(sz);
      int off = int'(a % 4) / nb * nb;
      return ((32'h1 << nb) - 32'h1) << off;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
      if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
      if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   int          m_phase, m_wait;
   logic [31:0] m_instr, m_load;
   logic        m_fault, m_enter;
   logic [1:0]  m_cause;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase <= P_START; m_wait <= 0; m_instr <= 32'h13; m_load <= '0;
         m_fault <= 1'b0; m_cause <= 2'd0; m_enter <= 1'b1;
      end else begin
         m_enter <= 1'b0;
         case (m_phase)
            P_START: begin m_phase <= P_FETCH; m_enter <= 1'b1; m_wait <= 0; end
            P_FETCH, P_RD, P_WR: begin
               if (ack) begin
                  if (m_phase == P_FETCH) begin
                     m_instr <= rdata; m_phase <= P_DECODE;
                  end else begin
                     if (m_phase == P_RD) m_load <= exp_load(rdata, alu_addr, mem_size, mem_unsigned);
                     m_phase <= P_FETCH; m_enter <= 1'b1;
                  end
                  m_wait <= 0;
               end else if (TO_ON && m_wait + 1 == TO_CYC) begin
                  m_phase <= P_FAULT; m_fault <= 1'b1; m_cause <= 2'd2;
               end else begin
                  m_wait <= m_wait + 1;
               end
            end
            P_DECODE: begin
               m_wait <= 0;
               if (mem_read || mem_write) begin
                  if (misal(mem_size, alu_addr)) begin
                     m_phase <= P_FAULT; m_fault <= 1'b1; m_cause <= 2'd1;
                  end else begin
                     m_phase <= mem_read ? P_RD : P_WR;
                  end
               end else begin
                  m_phase <= P_FETCH; m_enter <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [31:0] e_addr, e_sel, e_wdata;
   logic        e_rd, e_wr, e_fp, e_fi;

   always @(negedge clk) begin
      e_addr = '0; e_sel = '0; e_wdata = '0;
      e_rd = 1'b0; e_wr = 1'b0; e_fp = 1'b1; e_fi = 1'b1;
      case (m_phase)
         P_FETCH: begin
            e_rd = 1'b1; e_addr = pc & ~32'h3; e_sel = 32'hF; e_fi = !ack;
         end
         P_DECODE: e_fp = mem_read || mem_write;
         P_RD, P_WR: begin
            e_rd = (m_phase == P_RD); e_wr = (m_phase == P_WR);
            e_addr = alu_addr & ~32'h3;
            e_sel = exp_sel(mem_size, alu_addr);
            e_wdata = exp_wdata(mem_size, store_data);
            e_fp = !ack;
         end
         default: ;
      endcase
      check("read", 32'(o_read), 32'(e_rd));
      check("write", 32'(o_write), 32'(e_wr));
      check("address", o_address, e_addr);
      check("sel", 32'(o_sel), e_sel);
      check("wdata", o_wdata, e_wdata);
      check("freeze_pc", 32'(o_freeze_pc), 32'(e_fp));
      check("freeze_instr", 32'(o_freeze_instr), 32'(e_fi));
      check("instr", o_instr, m_instr);
      check("load_data", o_load_data, m_load);
      check("fault", 32'(o_fault), 32'(m_fault));
      check("fault_cause", 32'(o_fault_cause), 32'(m_cause));
   end

   // ---------------- stimulus ----------------
   int fault_cycles = 0;

   initial begin
      rst = 1'b1; ack = 1'b1; rdata = 32'h00A0_0093; pc = 32'h100;
      mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'd0; mem_unsigned = 1'b0;
      alu_addr = '0; store_data = '0;

      repeat (2) @(negedge clk);
      check("rst_instr", o_instr, 32'h13);
      check("rst_freeze_pc", 32'(o_freeze_pc), 32'h1);
      check("rst_read", 32'(o_read), 32'h0);
      check("rst_cause", 32'(o_fault_cause), 32'h0);

      // ALU instruction
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); check("start_read", 32'(o_read), 32'h0);
      @(negedge clk); check("fetch_read", 32'(o_read), 32'h1);
      check("fetch_addr", o_address, 32'h100);
      @(negedge clk); check("alu_instr", o_instr, 32'h00A0_0093);
      check("alu_freeze_pc", 32'(o_freeze_pc), 32'h0);
      $display("txn alu: instr=%h", o_instr);

      // signed byte load
      @(posedge clk); #1;
      mem_read = 1'b1; mem_size = 2'd0; alu_addr = 32'h1003; rdata = 32'h80FF_1234;
      @(negedge clk);
      @(negedge clk); check("ld_dec_freeze_pc", 32'(o_freeze_pc), 32'h1);
      @(negedge clk); check("ld_addr", o_address, 32'h1000);
      check("ld_sel", 32'(o_sel), 32'h8);
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b1; mem_size = 2'd1; alu_addr = 32'h2002;
      store_data = 32'h1234_BEEF;
      @(negedge clk); check("ld_data", o_load_data, 32'hFFFF_FF80);
      $display("txn load byte: load_data=%h", o_load_data);

      // half store
      @(negedge clk);
      @(negedge clk); check("st_write", 32'(o_write), 32'h1);
      check("st_sel", 32'(o_sel), 32'hC);
      check("st_wdata", o_wdata, 32'hBEEF_BEEF);
      check("st_freeze_pc", 32'(o_freeze_pc), 32'h0);
      $display("txn store half: wdata=%h sel=%b", o_wdata, o_sel);

      // misaligned word load
      @(posedge clk); #1;
      mem_write = 1'b0; mem_read = 1'b1; mem_size = 2'd2; alu_addr = 32'h3001;
      @(negedge clk); check("st_next_fetch", 32'(o_read), 32'h1);
      @(negedge clk); check("mis_dec_read", 32'(o_read), 32'h0);
      @(negedge clk); check("mis_fault", 32'(o_fault), 32'h1);
      check("mis_cause", 32'(o_fault_cause), 32'h1);
      repeat (3) begin
         @(negedge clk);
         check("mis_hold", 32'(o_fault), 32'h1);
         check("mis_hold_read", 32'(o_read), 32'h0);
      end
      $display("txn misaligned: fault=%b cause=%b", o_fault, o_fault_cause);

      // read+write together, then reset during DATA_RD
      @(posedge clk); #1;
      rst = 1'b1; mem_write = 1'b1; alu_addr = 32'h4000;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(posedge clk); #1 ack = 1'b0;
      @(negedge clk);
      @(negedge clk); check("both_read", 32'(o_read), 32'h1);
      check("both_write", 32'(o_write), 32'h0);
      #2 rst = 1'b1;
      #1 check("rst_async_read", 32'(o_read), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; ack = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk); check("restart_start", 32'(o_read), 32'h0);
      @(negedge clk); check("restart_fetch", 32'(o_read), 32'h1);
      $display("txn reset mid-read: restarted");

`ifdef T03_REQ_TIMEOUT_EN
      @(posedge clk); #1 rst = 1'b1; ack = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      repeat (TO_CYC) begin
         @(negedge clk); check("to_read", 32'(o_read), 32'h1);
      end
      @(negedge clk); check("to_fault", 32'(o_fault), 32'h1);
      check("to_cause", 32'(o_fault_cause), 32'h2);
      $display("txn timeout: cause=%b", o_fault_cause);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0; rdata = 32'h0000_0033;
      repeat (TO_CYC) @(posedge clk);
      #1 ack = 1'b1;
      @(negedge clk); check("to_edge_fi", 32'(o_freeze_instr), 32'h0);
      @(negedge clk); check("to_edge_fault", 32'(o_fault), 32'h0);
      check("to_edge_instr", o_instr, 32'h33);
      $display("txn ack at limit: fault=%b", o_fault);
`endif

      // random traffic
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1;
         ack = ($urandom_range(0, 3) != 0);
         rdata = $urandom;
         if (rst) begin
            rst = 1'b0;
         end else if (m_phase == P_FAULT) begin
            fault_cycles++;
            if (fault_cycles >= 3) begin
               rst = 1'b1;
               fault_cycles = 0;
            end
         end
         if (m_phase == P_FETCH && m_enter) begin
            pc = $urandom;
            {mem_read, mem_write} = 2'($urandom_range(0, 3));
            mem_size = 2'($urandom_range(0, 3));
            mem_unsigned = 1'($urandom_range(0, 1));
            store_data = $urandom;
            alu_addr = $urandom;
            if ($urandom_range(0, 15) != 0)
               alu_addr = alu_addr - (alu_addr % nbytes(mem_size));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
